// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and defaults for the PLL lock supervisor and its synchronizer.
package pll_sup_pkg;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2,
    HOLD   = 2'd3
  } sup_state_t;

  localparam int unsigned STABLE_CYCLES_DEF = 1024;
  localparam int unsigned HOLD_CYCLES_DEF   = 16;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Lock inputs, host controls and reset/status outputs of the PLL lock supervisor.
interface pll_lock_supervisor_if #(
  parameter int unsigned CNT_W = 8
);

  logic             locked;
  logic             clear_sticky;
  logic             sys_resetn;
  logic             ready;
  logic             lost_sticky;
  logic [CNT_W-1:0] loss_count;

  // Environment side: drives the raw lock flag and the sticky clear pulse.
  modport master (
    output locked,
    output clear_sticky,
    input  sys_resetn,
    input  ready,
    input  lost_sticky,
    input  loss_count
  );

  // Supervisor side.
  modport slave (
    input  locked,
    input  clear_sticky,
    output sys_resetn,
    output ready,
    output lost_sticky,
    output loss_count
  );

endinterface

// File: rtl/pll_lock_sync.sv
// Generic 2-flop synchronizer for asynchronous level inputs; synchronous active-low reset to 0.
module pll_lock_sync #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Qualifies the PLL lock, generates the downstream synchronous reset/ready and tracks lock losses.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                  clock_in,
  input  logic                  resetn,
  pll_lock_supervisor_if.slave  bus
);

  localparam int unsigned CntW = $clog2(max_u(STABLE_CYCLES, HOLD_CYCLES) + 1);

  localparam logic [CntW-1:0] StableLast = CntW'(STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] HoldLast   = CntW'(HOLD_CYCLES - 1);

  logic locked_s;

  pll_lock_sync #(
    .Width (1)
  ) u_lock_sync (
    .clk_i  (clock_in),
    .rst_ni (resetn),
    .d_i    (bus.locked),
    .q_o    (locked_s)
  );

  sup_state_t       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             lost_q, lost_d;
  logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;
  logic             sys_resetn_q;
  logic             ready_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lost_d     = lost_q;
    loss_cnt_d = loss_cnt_q;

    // A loss in the same cycle overrides the clear below.
    if (bus.clear_sticky) begin
      lost_d = 1'b0;
    end

    unique case (state_q)
      WAIT: begin
        if (locked_s) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (!locked_s) begin
          state_d = WAIT;
        end else if (cnt_q == StableLast) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d = HOLD;
          cnt_d   = '0;
          lost_d  = 1'b1;
          if (loss_cnt_q != '1) begin
            loss_cnt_d = loss_cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (cnt_q == HoldLast) begin
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Outputs are decoded from the next state so they move on the transition edge.
  always_ff @(posedge clock_in) begin
    if (!resetn) begin
      state_q      <= WAIT;
      cnt_q        <= '0;
      lost_q       <= 1'b0;
      loss_cnt_q   <= '0;
      sys_resetn_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lost_q       <= lost_d;
      loss_cnt_q   <= loss_cnt_d;
      sys_resetn_q <= (state_d == RUN);
      ready_q      <= (state_d == RUN);
    end
  end

  assign bus.sys_resetn  = sys_resetn_q;
  assign bus.ready       = ready_q;
  assign bus.lost_sticky = lost_q;
  assign bus.loss_count  = loss_cnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed scoreboard bench for pll_lock_supervisor with STABLE_CYCLES=8, HOLD_CYCLES=4, CNT_W=2.
module tb_pll_lock_supervisor;
  import pll_sup_pkg::*;

  localparam int unsigned Stable = 8;
  localparam int unsigned Hold   = 4;
  localparam int unsigned CntW   = 2;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pll_lock_supervisor_if #(.CNT_W(CntW)) bus ();

  pll_lock_supervisor #(
    .STABLE_CYCLES (Stable),
    .HOLD_CYCLES   (Hold),
    .CNT_W         (CntW)
  ) dut (
    .clock_in (clk),
    .resetn   (rst_n),
    .bus      (bus)
  );

  typedef struct {
    string           tag;
    logic            srn;
    logic            rdy;
    logic            lost;
    logic [CntW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [CntW-1:0] exp_cnt;
  logic            exp_lost;
  int              edge_idx;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic srn, input logic rdy,
                          input logic lost, input logic [CntW-1:0] cnt);
    exp_t e;
    e.tag  = tag;
    e.srn  = srn;
    e.rdy  = rdy;
    e.lost = lost;
    e.cnt  = cnt;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    chk(e.tag, {27'd0, bus.sys_resetn, bus.ready, bus.lost_sticky, bus.loss_count},
        {27'd0, e.srn, e.rdy, e.lost, e.cnt});
  endtask

  // Returns the index of the edge after which sys_resetn is first seen high, -1 on timeout.
  task automatic wait_release(input int start, output int idx);
    idx = -1;
    for (int e = start; e < start + 60; e++) begin
      tick();
      if (bus.sys_resetn === 1'b1) begin
        idx = e;
        break;
      end
    end
  endtask

  task automatic do_loss(input string tag, input bit clr);
    bus.locked = 1'b0;
    tick();
    bus.locked = 1'b1;
    push_exp({tag, "_edge0"}, 1'b1, 1'b1, exp_lost, exp_cnt);
    check_pop();
    tick();
    push_exp({tag, "_edge1"}, 1'b1, 1'b1, exp_lost, exp_cnt);
    check_pop();
    if (clr) bus.clear_sticky = 1'b1;
    tick();
    bus.clear_sticky = 1'b0;
    if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    exp_lost = 1'b1;
    push_exp({tag, "_hold"}, 1'b0, 1'b0, exp_lost, exp_cnt);
    check_pop();
    wait_release(3, edge_idx);
    chk({tag, "_relock_edge"}, edge_idx, Hold + 1 + Stable + 2);
    push_exp({tag, "_run"}, 1'b1, 1'b1, exp_lost, exp_cnt);
    check_pop();
  endtask

  task automatic clear_alone(input string tag);
    bus.clear_sticky = 1'b1;
    tick();
    bus.clear_sticky = 1'b0;
    exp_lost = 1'b0;
    push_exp(tag, 1'b1, 1'b1, exp_lost, exp_cnt);
    check_pop();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n            = 1'b0;
    bus.locked       = 1'b1;
    bus.clear_sticky = 1'b0;
    exp_cnt          = '0;
    exp_lost         = 1'b0;

    // Reset values with lock present.
    repeat (3) begin
      tick();
      push_exp("reset", 1'b0, 1'b0, 1'b0, 2'd0);
      check_pop();
    end

    // Clean lock-up.
    rst_n = 1'b1;
    wait_release(0, edge_idx);
    chk("lockup_edge", edge_idx, Stable + 2);
    push_exp("lockup_run", 1'b1, 1'b1, 1'b0, 2'd0);
    check_pop();

    // Glitch during SETTLE restarts qualification.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (7) tick();
    bus.locked = 1'b0;
    tick();
    bus.locked = 1'b1;
    push_exp("settle_glitch", 1'b0, 1'b0, 1'b0, 2'd0);
    check_pop();
    wait_release(0, edge_idx);
    chk("glitch_relock_edge", edge_idx, Stable + 2);
    push_exp("glitch_run", 1'b1, 1'b1, 1'b0, 2'd0);
    check_pop();

    // Losses in RUN, saturation, clear collision.
    do_loss("loss1", 1'b0);
    do_loss("loss2", 1'b0);
    do_loss("loss3", 1'b0);
    do_loss("loss4", 1'b0);
    clear_alone("clear_before_loss5");
    do_loss("loss5_clr", 1'b1);
    clear_alone("clear_after_loss5");

    // Reset in the middle of HOLD.
    bus.locked = 1'b0;
    tick();
    bus.locked = 1'b1;
    tick();
    tick();
    tick();
    if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    push_exp("in_hold", 1'b0, 1'b0, 1'b1, exp_cnt);
    check_pop();
    rst_n = 1'b0;
    tick();
    push_exp("hold_reset", 1'b0, 1'b0, 1'b0, 2'd0);
    check_pop();
    chk("hold_reset_state", {30'd0, dut.state_q}, {30'd0, WAIT});
    rst_n = 1'b1;
    wait_release(0, edge_idx);
    chk("post_reset_edge", edge_idx, Stable + 2);
    push_exp("post_reset_run", 1'b1, 1'b1, 1'b0, 2'd0);
    check_pop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
